// File: rtl/acc_dec_pkg.sv
// rtl/acc_dec_pkg.sv - shared types and constants for the accumulator operand decoder
package acc_dec_pkg;

    localparam int W = 8;

    localparam logic KIND_AND = 1'b0;
    localparam logic KIND_XOR = 1'b1;

    typedef enum logic {SYNC, RUN} state_t;

    typedef struct packed {
        logic         kind;
        logic [W-1:0] data;
        logic [W-1:0] known;
    } entry_t;

endpackage

// File: rtl/acc_dec_fifo.sv
// rtl/acc_dec_fifo.sv - DEPTH-entry result FIFO with wrap-bit pointers
module acc_dec_fifo
    import acc_dec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  entry_t wdata,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    entry_t      mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) begin
            wr_d = wr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/acc_op_decoder.sv
// rtl/acc_op_decoder.sv - recovers XOR/AND operands from a stream of accumulator snapshots
module acc_op_decoder
    import acc_dec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           r,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_clear,
    input  logic           in_sel,
    input  logic [W-1:0]   in_q,
    input  logic [W/2-1:0] in_l,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_kind,
    output logic [W-1:0]   out_data,
    output logic [W-1:0]   out_known,
    output logic           err
);

    state_t       state_q, state_d;
    logic [W-1:0] prev_q, prev_d;
    logic         err_q, err_d;

    logic         fifo_full;
    logic         fifo_empty;
    logic         accept;
    logic         push;
    logic         pop;
    logic [W-1:0] p;
    entry_t       dec;
    entry_t       head;

    assign in_ready = !fifo_full;
    assign accept   = in_valid && !fifo_full;
    assign pop      = !fifo_empty && out_ready;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        err_d   = err_q;
        push    = 1'b0;
        dec     = '0;
        p       = in_clear ? '0 : prev_q;

        if (in_sel) begin
            dec.kind  = KIND_XOR;
            dec.data  = in_q ^ p;
            dec.known = '1;
        end else begin
            dec.kind  = KIND_AND;
            dec.data  = in_q & p;
            dec.known = p;
        end

        // Without a clear, the first snapshot after SYNC only seeds the predecessor.
        if (accept) begin
            push    = (state_q == RUN) || in_clear;
            prev_d  = in_q;
            state_d = RUN;
            if (push) begin
                if (in_sel && (dec.data[W-1:W/2] != in_l)) begin
                    err_d = 1'b1;
                end
                if (!in_sel && ((in_q & ~p) != '0)) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= SYNC;
            prev_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            err_q   <= err_d;
        end
    end

    acc_dec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (r),
        .push  (push),
        .pop   (pop),
        .wdata (dec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Head storage is not reset, so outputs read as zero whenever nothing is queued.
    assign out_valid = !fifo_empty;
    assign out_kind  = fifo_empty ? 1'b0 : head.kind;
    assign out_data  = fifo_empty ? '0   : head.data;
    assign out_known = fifo_empty ? '0   : head.known;
    assign err       = err_q;

endmodule

// File: tb/tb_acc_op_decoder.sv
// tb/tb_acc_op_decoder.sv - randomized and directed checks of acc_op_decoder against a queue model
module tb_acc_op_decoder;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic       kind;
        logic [7:0] data;
        logic [7:0] known;
    } ent_t;

    logic       clk = 1'b0;
    logic       r = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_clear = 1'b0;
    logic       in_sel = 1'b0;
    logic [7:0] in_q = 8'h00;
    logic [3:0] in_l = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_kind;
    logic [7:0] out_data;
    logic [7:0] out_known;
    logic       err;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    ent_t       mq[$];
    logic [7:0] m_prev = 8'h00;
    bit         m_synced = 1'b0;
    bit         m_err = 1'b0;

    acc_op_decoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .r         (r),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_clear  (in_clear),
        .in_sel    (in_sel),
        .in_q      (in_q),
        .in_l      (in_l),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_data  (out_data),
        .out_known (out_known),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a predecessor value, a sync flag, a sticky error and a queue of results.
    always @(posedge clk or negedge r) begin
        bit         rdy;
        logic [7:0] p;
        ent_t       e;
        if (!r) begin
            mq.delete();
            m_prev   = 8'h00;
            m_synced = 1'b0;
            m_err    = 1'b0;
        end else begin
            rdy = (mq.size() < DEPTH);
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) begin
                if (m_synced || in_clear) begin
                    p = in_clear ? 8'h00 : m_prev;
                    if (in_sel) begin
                        e.kind  = 1'b1;
                        e.data  = in_q ^ p;
                        e.known = 8'hFF;
                        if (e.data[7:4] != in_l) m_err = 1'b1;
                    end else begin
                        e.kind  = 1'b0;
                        e.data  = in_q & p;
                        e.known = p;
                        if ((in_q & ~p) != 8'h00) m_err = 1'b1;
                    end
                    mq.push_back(e);
                end
                m_prev   = in_q;
                m_synced = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        bit   ev;
        ent_t h;
        if (check_en) begin
            ev = (mq.size() > 0);
            h  = ev ? mq[0] : ent_t'(0);
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("err", err, m_err);
            chk("out_kind", out_kind, h.kind);
            chk("out_data", out_data, h.data);
            chk("out_known", out_known, h.known);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic c, input logic s,
                         input logic [7:0] q, input logic [3:0] l);
        in_valid = v;
        in_clear = c;
        in_sel   = s;
        in_q     = q;
        in_l     = l;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    endtask

    task automatic do_reset();
        idle();
        r = 1'b0;
        cyc();
        cyc();
        r = 1'b1;
    endtask

    initial begin
        logic [7:0] qs [6];
        logic [7:0] rq;
        logic [7:0] rp;
        logic [7:0] rx;

        qs[0] = 8'h11; qs[1] = 8'h22; qs[2] = 8'h33;
        qs[3] = 8'h44; qs[4] = 8'h55; qs[5] = 8'h66;

        cyc();
        check_en = 1'b1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_data", out_data, 8'h00);
        do_reset();

        // Clear-first XOR step decodes against zero.
        drive(1'b1, 1'b1, 1'b1, 8'h5A, 4'h5);
        cyc();
        idle();
        chk("t1_kind", out_kind, 1'b1);
        chk("t1_data", out_data, 8'h5A);
        chk("t1_known", out_known, 8'hFF);
        chk("t1_err", err, 1'b0);
        cyc();

        do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'hF0, 4'h0);
        cyc();
        idle();
        chk("t2_sync_nopush", out_valid, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'hFF, 4'h0);
        cyc();
        idle();
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_data", out_data, 8'h0F);
        chk("t2_err", err, 1'b0);
        cyc();
        chk("t2_single", out_valid, 1'b0);

        do_reset();
        drive(1'b1, 1'b0, 1'b0, 8'hF0, 4'h0);
        cyc();
        drive(1'b1, 1'b0, 1'b0, 8'h30, 4'h0);
        cyc();
        idle();
        chk("t3_kind", out_kind, 1'b0);
        chk("t3_data", out_data, 8'h30);
        chk("t3_known", out_known, 8'hF0);
        chk("t3_err0", err, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h31, 4'h0);
        cyc();
        idle();
        chk("t3_err1", err, 1'b1);
        repeat (3) cyc();
        chk("t3_err_sticky", err, 1'b1);

        // Fill past capacity with the consumer stalled.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rq = qs[i];
            drive(1'b1, 1'b1, 1'b1, rq, rq[7:4]);
            cyc();
            if (i == DEPTH - 1) chk("t4_full_ready", in_ready, 1'b0);
        end
        idle();
        chk("t4_head", out_data, 8'h11);
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk("t4_order", out_data, qs[k]);
            cyc();
        end
        chk("t4_drained", out_valid, 1'b0);
        chk("t4_err0", err, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h4B, 4'h0);
        cyc();
        idle();
        chk("t4_prev_kept", out_data, 8'h0F);
        cyc();

        drive(1'b1, 1'b0, 1'b1, 8'hE8, 4'h3);
        cyc();
        idle();
        chk("t5_err", err, 1'b1);
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_data", out_data, 8'hA3);
        cyc();

        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rq = qs[i];
            drive(1'b1, 1'b1, 1'b1, rq, rq[7:4]);
            cyc();
        end
        idle();
        chk("t6_queued", out_valid, 1'b1);
        #2;
        r = 1'b0;
        #1;
        chk("t6_async_clear", out_valid, 1'b0);
        cyc();
        r = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h77, 4'h7);
        cyc();
        idle();
        chk("t6_sync_nopush", out_valid, 1'b0);
        cyc();
        chk("t6_still_empty", out_valid, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 0) do_reset();
            out_ready = ($urandom_range(0, 3) != 0);
            rq = 8'($urandom);
            in_clear = ($urandom_range(0, 7) == 0);
            in_sel   = $urandom_range(0, 1);
            rp = in_clear ? 8'h00 : m_prev;
            if (!in_sel && $urandom_range(0, 3) != 0) rq = rq & rp;
            rx = rq ^ rp;
            in_q     = rq;
            in_l     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : rx[7:4];
            in_valid = ($urandom_range(0, 2) != 0);
            cyc();
        end

        idle();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
